// File: rtl/cd_drive_pkg.sv
// cd_drive_pkg: shared types and constants for the CD drive sequencer.
//   cd_op_e      command opcodes from the CDIC
//   drv_state_e  sequencer states (also driven out as drv_state)
//   msf_t        BCD minute:second:frame address
//   bcd_to_bin / msf_bcd_ok  BCD helpers used by the MSF converter
package cd_drive_pkg;

  typedef enum logic [1:0] {
    OP_NOP       = 2'd0,
    OP_SEEK_PLAY = 2'd1,
    OP_PAUSE     = 2'd2,
    OP_RESUME    = 2'd3
  } cd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_PLAYING = 2'd2,
    ST_PAUSED  = 2'd3
  } drv_state_e;

  typedef struct packed {
    logic [7:0] mm;
    logic [7:0] ss;
    logic [7:0] ff;
  } msf_t;

  localparam logic [31:0] FRAMES_PER_SEC = 32'd75;
  localparam logic [31:0] SECS_PER_MIN   = 32'd60;
  localparam logic [31:0] LBA_OFFSET     = 32'd150;

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] b);
    return {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
  endfunction

  // Every nibble must be a decimal digit; seconds and frames also have range caps.
  function automatic logic msf_bcd_ok(input msf_t m);
    return (m.mm[7:4] <= 4'd9) && (m.mm[3:0] <= 4'd9) &&
           (m.ss[7:4] <= 4'd9) && (m.ss[3:0] <= 4'd9) &&
           (m.ff[7:4] <= 4'd9) && (m.ff[3:0] <= 4'd9) &&
           (m.ss <= 8'h59) && (m.ff <= 8'h74);
  endfunction

endpackage

// File: rtl/cd_msf_to_lba.sv
// cd_msf_to_lba: two-stage BCD MSF to LBA converter.
//   clk, reset  clock, synchronous active-high reset (valid pipeline only)
//   in_valid    start a conversion of in_msf
//   in_msf      BCD mm:ss:ff
//   in_err      combinational: in_msf is not a legal BCD MSF address
//   out_valid   result strobe, two cycles after an accepted in_valid
//   out_lba     (mm*60+ss)*75+ff-150, clamped at 0
// Illegal addresses are never launched into the pipeline.
module cd_msf_to_lba
  import cd_drive_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  msf_t        in_msf,
  output logic        in_err,
  output logic        out_valid,
  output logic [31:0] out_lba
);

  logic       vld_p1_q, vld_p1_d;
  logic [6:0] mm_p1_q, mm_p1_d, ss_p1_q, ss_p1_d, ff_p1_q, ff_p1_d;
  logic       vld_p2_q, vld_p2_d;
  logic [31:0] lba_p2_q, lba_p2_d;
  logic [31:0] total;

  // Addresses before 00:02:00 map below LBA 0; pin them to the first sector.
  function automatic logic [31:0] sat_lba(input logic [31:0] t);
    return (t < LBA_OFFSET) ? 32'd0 : (t - LBA_OFFSET);
  endfunction

  assign in_err = !msf_bcd_ok(in_msf);

  // Stage 1: BCD to binary
  always_comb begin
    vld_p1_d = in_valid && !in_err;
    mm_p1_d  = bcd_to_bin(in_msf.mm);
    ss_p1_d  = bcd_to_bin(in_msf.ss);
    ff_p1_d  = bcd_to_bin(in_msf.ff);
  end

  // Stage 2: multiply-add and offset
  always_comb begin
    total    = (32'(mm_p1_q) * SECS_PER_MIN + 32'(ss_p1_q)) * FRAMES_PER_SEC + 32'(ff_p1_q);
    lba_p2_d = sat_lba(total);
    vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    mm_p1_q  <= mm_p1_d;
    ss_p1_q  <= ss_p1_d;
    ff_p1_q  <= ff_p1_d;
    lba_p2_q <= lba_p2_d;
  end

  assign out_valid = vld_p2_q;
  assign out_lba   = lba_p2_q;

endmodule

// File: rtl/cd_drive_sequencer.sv
// cd_drive_sequencer: CD drive mechanism emulation in front of the sector cache.
//   clk, reset        clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready low only while converting)
//   cmd_op, cmd_msf   opcode (cd_op_e) and BCD MSF for SEEK_PLAY
//   cmd_error         one-cycle pulse when a SEEK_PLAY address is illegal
//   double_speed      select 150 Hz sector ticks
//   seek_lba(_valid)  seek request to the cache
//   sector_tick       one-cycle pulse per sector period while playing
//   sector_delivered  cache delivered one sector
//   current_lba       LBA of the next sector to be delivered
//   drv_state         drv_state_e
//   underrun          one-cycle pulse after TIMEOUT_SECTORS missed ticks
// Build option: define CD_DOUBLE_SPEED_EN to honour double_speed; otherwise
// the input is ignored and the divider is fixed at CLK_HZ/SECTOR_RATE.
module cd_drive_sequencer
  import cd_drive_pkg::*;
#(
  parameter int CLK_HZ          = 30000000,
  parameter int SECTOR_RATE     = 75,
  parameter int TIMEOUT_SECTORS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_msf,
  output logic        cmd_error,
  input  logic        double_speed,
  output logic [31:0] seek_lba,
  output logic        seek_lba_valid,
  output logic        sector_tick,
  input  logic        sector_delivered,
  output logic [31:0] current_lba,
  output logic [1:0]  drv_state,
  output logic        underrun
);

  localparam logic [31:0] DIV_M1     = 32'(CLK_HZ / SECTOR_RATE - 1);
  localparam logic [3:0]  MISS_LIMIT = 4'(TIMEOUT_SECTORS - 1);

  drv_state_e  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d, cmd_error_q, cmd_error_d;
  logic        seek_valid_q, seek_valid_d, tick_q, tick_d, underrun_q, underrun_d;
  logic [31:0] seek_lba_q, seek_lba_d, current_lba_q, current_lba_d;
  logic [31:0] div_cnt_q, div_cnt_d, div_m1;
  logic        armed_q, armed_d, since_q, since_d;
  logic [3:0]  miss_q, miss_d;

  cd_op_e      op;
  logic        accept, seek_acc, pause_acc, resume_acc, seek_fire, deliver;
  logic        conv_err, conv_valid;
  logic [31:0] conv_lba;

`ifdef CD_DOUBLE_SPEED_EN
  localparam logic [31:0] DIV_HALF_M1 = 32'(CLK_HZ / SECTOR_RATE / 2 - 1);
  assign div_m1 = double_speed ? DIV_HALF_M1 : DIV_M1;
`else
  logic unused_double_speed;
  assign unused_double_speed = double_speed;
  assign div_m1 = DIV_M1;
`endif

  assign op         = cd_op_e'(cmd_op);
  assign accept     = cmd_valid && cmd_ready_q;
  assign seek_acc   = accept && (op == OP_SEEK_PLAY);
  assign pause_acc  = accept && (op == OP_PAUSE) && (state_q == ST_PLAYING);
  assign resume_acc = accept && (op == OP_RESUME) && (state_q == ST_PAUSED);
  assign seek_fire  = conv_valid || resume_acc;
  // A sector landing on the same edge as a new seek belongs to the old position.
  assign deliver    = sector_delivered && !seek_acc && !resume_acc &&
                      ((state_q == ST_PLAYING) || (state_q == ST_PAUSED));

  cd_msf_to_lba u_msf_to_lba (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (seek_acc),
    .in_msf    (msf_t'(cmd_msf)),
    .in_err    (conv_err),
    .out_valid (conv_valid),
    .out_lba   (conv_lba)
  );

  always_comb begin
    state_d       = state_q;
    cmd_error_d   = 1'b0;
    seek_valid_d  = 1'b0;
    seek_lba_d    = seek_lba_q;
    current_lba_d = current_lba_q;
    div_cnt_d     = div_cnt_q;
    tick_d        = 1'b0;
    underrun_d    = 1'b0;
    armed_d       = armed_q;
    since_d       = since_q;
    miss_d        = miss_q;

    if (seek_acc) begin
      if (conv_err) cmd_error_d = 1'b1;
      else          state_d     = ST_CONVERT;
    end else if (pause_acc) begin
      state_d = ST_PAUSED;
    end else if (resume_acc) begin
      state_d      = ST_PLAYING;
      seek_valid_d = 1'b1;
      seek_lba_d   = current_lba_q;
    end

    if (deliver) current_lba_d = current_lba_q + 32'd1;

    if (conv_valid) begin
      state_d       = ST_PLAYING;
      seek_valid_d  = 1'b1;
      seek_lba_d    = conv_lba;
      current_lba_d = conv_lba;
    end

    // ">=" lets a switch to the shorter period fire on the next cycle.
    if (seek_fire) begin
      div_cnt_d = 32'd0;
    end else if ((state_q == ST_PLAYING) && (state_d == ST_PLAYING)) begin
      if (div_cnt_q >= div_m1) begin
        tick_d    = 1'b1;
        div_cnt_d = 32'd0;
      end else begin
        div_cnt_d = div_cnt_q + 32'd1;
      end
    end

    // Underrun watch starts only after the first sector following a seek,
    // so the cache's seek latency is never counted as a miss.
    if (seek_fire || (state_q != ST_PLAYING)) begin
      armed_d = 1'b0;
      since_d = 1'b0;
      miss_d  = 4'd0;
    end else begin
      if (deliver) begin
        armed_d = 1'b1;
        since_d = 1'b1;
        miss_d  = 4'd0;
      end
      if (tick_d) begin
        since_d = 1'b0;
        if (armed_q && !since_q && !deliver) begin
          if (miss_q == MISS_LIMIT) begin
            underrun_d = 1'b1;
            miss_d     = 4'd0;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
      end
    end

    cmd_ready_d = (state_d != ST_CONVERT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      cmd_error_q   <= 1'b0;
      seek_valid_q  <= 1'b0;
      seek_lba_q    <= 32'd0;
      current_lba_q <= 32'd0;
      div_cnt_q     <= 32'd0;
      tick_q        <= 1'b0;
      underrun_q    <= 1'b0;
      armed_q       <= 1'b0;
      since_q       <= 1'b0;
      miss_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      cmd_error_q   <= cmd_error_d;
      seek_valid_q  <= seek_valid_d;
      seek_lba_q    <= seek_lba_d;
      current_lba_q <= current_lba_d;
      div_cnt_q     <= div_cnt_d;
      tick_q        <= tick_d;
      underrun_q    <= underrun_d;
      armed_q       <= armed_d;
      since_q       <= since_d;
      miss_q        <= miss_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign cmd_error      = cmd_error_q;
  assign seek_lba       = seek_lba_q;
  assign seek_lba_valid = seek_valid_q;
  assign sector_tick    = tick_q;
  assign current_lba    = current_lba_q;
  assign drv_state      = state_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_cd_drive_sequencer.sv
// tb_cd_drive_sequencer: directed bench for cd_drive_sequencer with
// CLK_HZ=7500 (sector period 100 clocks, 50 at double speed when
// CD_DOUBLE_SPEED_EN is defined).
module tb_cd_drive_sequencer;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_error, double_speed;
  logic [1:0]  cmd_op, drv_state;
  logic [23:0] cmd_msf;
  logic [31:0] seek_lba, current_lba;
  logic        seek_lba_valid, sector_tick, sector_delivered, underrun;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int DIV_SLOW = 100;
`ifdef CD_DOUBLE_SPEED_EN
  localparam int DIV_FAST = 50;
`else
  localparam int DIV_FAST = 100;
`endif

  always #5 clk = ~clk;

  cd_drive_sequencer #(
    .CLK_HZ(7500), .SECTOR_RATE(75), .TIMEOUT_SECTORS(4)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_msf(cmd_msf), .cmd_error(cmd_error),
    .double_speed(double_speed), .seek_lba(seek_lba), .seek_lba_valid(seek_lba_valid),
    .sector_tick(sector_tick), .sector_delivered(sector_delivered),
    .current_lba(current_lba), .drv_state(drv_state), .underrun(underrun)
  );

  // Presents one command for one clock; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [23:0] msf, input logic dlv);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_msf = msf; sector_delivered = dlv;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd0; sector_delivered = 1'b0;
  endtask

  task automatic deliver_one;
    @(negedge clk) sector_delivered = 1'b1;
    @(negedge clk) sector_delivered = 1'b0;
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (sector_tick !== 1'b1 && cycles < 1000);
    n_checks++;
    if (sector_tick !== 1'b1) $display("FAIL tick_timeout: no sector_tick after %0d cycles", cycles);
    else n_pass++;
  endtask

  task automatic test_reset;
    int act;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_msf = 24'd0;
    double_speed = 1'b0; sector_delivered = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cmd_error, seek_lba_valid, sector_tick, underrun, drv_state} !== 6'd0)
      $display("FAIL reset_flags: got %b expected 000000", {cmd_error, seek_lba_valid, sector_tick, underrun, drv_state});
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else n_pass++;
    n_checks++;
    if (seek_lba !== 32'd0 || current_lba !== 32'd0)
      $display("FAIL reset_lba: got seek %0d cur %0d expected 0 0", seek_lba, current_lba);
    else n_pass++;
    act = 0;
    repeat (500) begin
      @(negedge clk);
      if (sector_tick || seek_lba_valid || underrun || cmd_error || !cmd_ready) act++;
    end
    n_checks++;
    if (act !== 0) $display("FAIL idle_activity: got %0d active cycles expected 0", act); else n_pass++;
  endtask

  task automatic test_seek;
    int c;
    send_cmd(2'd1, 24'h000200, 1'b0);
    n_checks++;
    if ({drv_state, cmd_ready, seek_lba_valid} !== {2'd1, 1'b0, 1'b0})
      $display("FAIL convert_c1: got state %0d ready %b valid %b expected 1 0 0", drv_state, cmd_ready, seek_lba_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (seek_lba_valid !== 1'b0 || drv_state !== 2'd1)
      $display("FAIL convert_c2: got valid %b state %0d expected 0 1", seek_lba_valid, drv_state);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (seek_lba_valid !== 1'b1 || seek_lba !== 32'd0 || drv_state !== 2'd2 || current_lba !== 32'd0)
      $display("FAIL seek_0200: got valid %b lba %0d state %0d cur %0d expected 1 0 2 0",
               seek_lba_valid, seek_lba, drv_state, current_lba);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (seek_lba_valid !== 1'b0) $display("FAIL seek_strobe_len: got %b expected 0", seek_lba_valid); else n_pass++;
    wait_tick(c);
    n_checks++;
    if (c !== DIV_SLOW - 1) $display("FAIL first_tick: got %0d expected %0d", c + 1, DIV_SLOW); else n_pass++;
    wait_tick(c);
    n_checks++;
    if (c !== DIV_SLOW) $display("FAIL tick_spacing: got %0d expected %0d", c, DIV_SLOW); else n_pass++;
    send_cmd(2'd1, 24'h012345, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (seek_lba_valid !== 1'b1 || seek_lba !== 32'd6120 || current_lba !== 32'd6120)
      $display("FAIL seek_012345: got valid %b lba %0d cur %0d expected 1 6120 6120",
               seek_lba_valid, seek_lba, current_lba);
    else n_pass++;
  endtask

  task automatic test_pause_resume;
    int c, ticks;
    repeat (3) deliver_one;
    n_checks++;
    if (current_lba !== 32'd6123) $display("FAIL deliver_3: got %0d expected 6123", current_lba); else n_pass++;
    send_cmd(2'd2, 24'd0, 1'b0);
    n_checks++;
    if (drv_state !== 2'd3) $display("FAIL pause_state: got %0d expected 3", drv_state); else n_pass++;
    ticks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (sector_tick) ticks++;
    end
    n_checks++;
    if (ticks !== 0 || current_lba !== 32'd6123)
      $display("FAIL pause_hold: got ticks %0d cur %0d expected 0 6123", ticks, current_lba);
    else n_pass++;
    send_cmd(2'd3, 24'd0, 1'b0);
    n_checks++;
    if (seek_lba_valid !== 1'b1 || seek_lba !== 32'd6123 || drv_state !== 2'd2)
      $display("FAIL resume: got valid %b lba %0d state %0d expected 1 6123 2", seek_lba_valid, seek_lba, drv_state);
    else n_pass++;
    wait_tick(c);
    n_checks++;
    if (c !== DIV_SLOW) $display("FAIL resume_tick: got %0d expected %0d", c, DIV_SLOW); else n_pass++;
  endtask

  task automatic test_double_speed;
    int c;
    double_speed = 1'b1;
    wait_tick(c);
    wait_tick(c);
    n_checks++;
    if (c !== DIV_FAST) $display("FAIL fast_spacing_a: got %0d expected %0d", c, DIV_FAST); else n_pass++;
    wait_tick(c);
    n_checks++;
    if (c !== DIV_FAST) $display("FAIL fast_spacing_b: got %0d expected %0d", c, DIV_FAST); else n_pass++;
    double_speed = 1'b0;
    wait_tick(c);
    wait_tick(c);
    n_checks++;
    if (c !== DIV_SLOW) $display("FAIL slow_again: got %0d expected %0d", c, DIV_SLOW); else n_pass++;
  endtask

  task automatic test_underrun;
    int c;
    for (int k = 0; k < 6; k++) begin
      wait_tick(c);
      n_checks++;
      if (underrun !== 1'b0) $display("FAIL unarmed_tick%0d: got %b expected 0", k, underrun); else n_pass++;
    end
    deliver_one;
    for (int k = 0; k < 5; k++) begin
      wait_tick(c);
      n_checks++;
      if (underrun !== (k == 4)) $display("FAIL underrun_tick%0d: got %b expected %b", k, underrun, (k == 4));
      else n_pass++;
    end
  endtask

  task automatic test_error_drop;
    send_cmd(2'd1, 24'h001A00, 1'b0);
    n_checks++;
    if (cmd_error !== 1'b1 || drv_state !== 2'd2 || current_lba !== 32'd6124)
      $display("FAIL bad_msf: got err %b state %0d cur %0d expected 1 2 6124", cmd_error, drv_state, current_lba);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cmd_error !== 1'b0) $display("FAIL err_pulse_len: got %b expected 0", cmd_error); else n_pass++;
    send_cmd(2'd1, 24'h000100, 1'b1);
    n_checks++;
    if (drv_state !== 2'd1 || current_lba !== 32'd6124)
      $display("FAIL seek_drop: got state %0d cur %0d expected 1 6124", drv_state, current_lba);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (seek_lba_valid !== 1'b1 || seek_lba !== 32'd0 || current_lba !== 32'd0)
      $display("FAIL seek_0100_clamp: got valid %b lba %0d cur %0d expected 1 0 0", seek_lba_valid, seek_lba, current_lba);
    else n_pass++;
    repeat (2) deliver_one;
    send_cmd(2'd2, 24'd0, 1'b0);
    deliver_one;
    n_checks++;
    if (current_lba !== 32'd3 || drv_state !== 2'd3)
      $display("FAIL paused_deliver: got cur %0d state %0d expected 3 3", current_lba, drv_state);
    else n_pass++;
    send_cmd(2'd3, 24'd0, 1'b1);
    n_checks++;
    if (seek_lba_valid !== 1'b1 || seek_lba !== 32'd3 || current_lba !== 32'd3)
      $display("FAIL resume_drop: got valid %b lba %0d cur %0d expected 1 3 3", seek_lba_valid, seek_lba, current_lba);
    else n_pass++;
  endtask

  task automatic test_reset_mid_convert;
    int strobes;
    send_cmd(2'd1, 24'h012345, 1'b0);
    n_checks++;
    if (drv_state !== 2'd1) $display("FAIL mid_convert_state: got %0d expected 1", drv_state); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (seek_lba_valid) strobes++;
    end
    n_checks++;
    if (strobes !== 0 || drv_state !== 2'd0 || cmd_ready !== 1'b1 || current_lba !== 32'd0)
      $display("FAIL reset_convert: got strobes %0d state %0d ready %b cur %0d expected 0 0 1 0",
               strobes, drv_state, cmd_ready, current_lba);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_seek;
    test_pause_resume;
    test_double_speed;
    test_underrun;
    test_error_drop;
    test_reset_mid_convert;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
